// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered read data, occupancy count and threshold flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow detectors.
module sync_fifo_param #(
  parameter int WIDTH         = 8,
  parameter int POINTER       = 3,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               wr_en,
  input  logic               rd_en,
  output logic [WIDTH-1:0]   data_out,
  output logic               data_valid,
  output logic               wr_full,
  output logic               rd_empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [POINTER:0]   level,
  output logic               overflow,
  output logic               underflow
);
  localparam int DEPTH = 1 << POINTER;
  localparam int LW    = POINTER + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [POINTER:0] wr_ptr, rd_ptr;
  logic             wr_acc, rd_acc;

  // Flags decode the registered level, so acceptance always sees pre-edge state.
  assign wr_full      = (level == LW'(DEPTH));
  assign rd_empty     = (level == '0);
  assign almost_full  = (level >= LW'(AFULL_THRESH));
  assign almost_empty = (level <= LW'(AEMPTY_THRESH));

  assign wr_acc = wr_en & ~wr_full;
  assign rd_acc = rd_en & ~rd_empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc)
      mem[wr_ptr[POINTER-1:0]] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr[POINTER-1:0]];
      end
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && wr_full)  overflow  <= 1'b1;
      if (rd_en && rd_empty) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
